// File: rtl/imu_fusion_core_if.sv
// Request/ack handshake and sample bus between the sensor front end and imu_fusion_core.
// The master side issues requests and samples; the slave side is the fusion core.
interface imu_fusion_core_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16,
    parameter int ANG_W  = 32
);
    logic                       fuse_req;
    logic                       fuse_ack;
    logic                       busy;
    logic                       zero;
    logic [NUM_CH*DATA_W-1:0]   gyro_in;
    logic [NUM_CH*ANG_W-1:0]    acc_ang_in;
    logic [NUM_CH-1:0]          acc_mask;
    logic [NUM_CH*ANG_W-1:0]    angle_out;
    logic                       cal_done;

    modport master (
        output fuse_req, zero, gyro_in, acc_ang_in, acc_mask,
        input  fuse_ack, busy, angle_out, cal_done
    );

    modport slave (
        input  fuse_req, zero, gyro_in, acc_ang_in, acc_mask,
        output fuse_ack, busy, angle_out, cal_done
    );
endinterface

// File: rtl/imu_fusion_core.sv
// Per-channel complementary filter: gyro integration plus a 2^-ALPHA_SHIFT pull toward the accel angle.
// Optional gyro bias calibration over the first 2^CAL_SHIFT samples: `define IMU_FUSION_GYRO_BIAS_CAL_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for fuse_req; zero clears angles and seed flags
// S_CAPTURE | latch gyro, accel angles and mask; start at channel 0
// S_PREDICT | integrate gyro rate into the channel angle (saturating)
// S_CORRECT | seed or blend toward accel angle; publish after last channel
// S_ACK     | one-cycle fuse_ack
module imu_fusion_core #(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 16,
    parameter int ANG_W       = 32,
    parameter int GYRO_SHL    = 0,
    parameter int ALPHA_SHIFT = 6,
    parameter int CAL_SHIFT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    imu_fusion_core_if.slave  bus
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W = ANG_W + 2;
    localparam logic signed [ANG_W-1:0] ANG_MAX = {1'b0, {(ANG_W-1){1'b1}}};
    localparam logic signed [ANG_W-1:0] ANG_MIN = {1'b1, {(ANG_W-1){1'b0}}};

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("imu_fusion_core: NUM_CH out of range");
    end
    if (GYRO_SHL < 0 || GYRO_SHL > 8) begin : g_bad_gyro_shl
        $error("imu_fusion_core: GYRO_SHL out of range");
    end
    if (ALPHA_SHIFT < 0 || ALPHA_SHIFT > 15) begin : g_bad_alpha
        $error("imu_fusion_core: ALPHA_SHIFT out of range");
    end
    if (CAL_SHIFT < 0 || CAL_SHIFT > 16) begin : g_bad_cal_shift
        $error("imu_fusion_core: CAL_SHIFT out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_PREDICT,
        S_CORRECT,
        S_ACK
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_ack;
    logic                       w_last_ch;

    logic [CH_W-1:0]            r_ch;
    logic signed [DATA_W-1:0]   r_gyro [NUM_CH];
    logic signed [ANG_W-1:0]    r_acc  [NUM_CH];
    logic [NUM_CH-1:0]          r_mask;
    logic [NUM_CH-1:0]          r_seed;
    logic signed [ANG_W-1:0]    r_ang  [NUM_CH];
    logic signed [ANG_W-1:0]    r_pred;
    logic [NUM_CH*ANG_W-1:0]    r_angle_out;

    logic signed [DATA_W-1:0]   w_bias [NUM_CH];
    logic                       w_cal_active;

    logic signed [DATA_W:0]     w_gyro_diff;
    logic signed [EXT_W-1:0]    w_gyro_term;
    logic signed [EXT_W-1:0]    w_pred_sum;
    logic signed [ANG_W-1:0]    w_pred;
    logic signed [ANG_W:0]      w_err;
    logic signed [ANG_W:0]      w_err_sh;
    logic signed [EXT_W-1:0]    w_corr_sum;
    logic signed [ANG_W-1:0]    w_ang_new;

    function automatic logic signed [ANG_W-1:0] sat_ang(input logic signed [EXT_W-1:0] v);
        logic [EXT_W-ANG_W:0] top;
        top = v[EXT_W-1:ANG_W-1];
        if ((&top) || (~|top)) begin
            return v[ANG_W-1:0];
        end else if (v[EXT_W-1]) begin
            return ANG_MIN;
        end else begin
            return ANG_MAX;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.zero && bus.fuse_req) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: w_state_nxt = S_PREDICT;
            S_PREDICT: w_state_nxt = S_CORRECT;
            S_CORRECT: w_state_nxt = w_last_ch ? S_ACK : S_PREDICT;
            S_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Arithmetic is done two bits wider than the angle so saturation sees the true sum.
    always_comb begin
        w_gyro_diff = $signed({r_gyro[r_ch][DATA_W-1], r_gyro[r_ch]})
                    - $signed({w_bias[r_ch][DATA_W-1], w_bias[r_ch]});
        w_gyro_term = w_cal_active ? '0 : (EXT_W'(w_gyro_diff) <<< GYRO_SHL);
        w_pred_sum  = EXT_W'(r_ang[r_ch]) + w_gyro_term;
        w_pred      = sat_ang(w_pred_sum);
        w_err       = (ANG_W+1)'(r_acc[r_ch]) - (ANG_W+1)'(r_pred);
        w_err_sh    = w_err >>> ALPHA_SHIFT;
        w_corr_sum  = EXT_W'(r_pred) + EXT_W'(w_err_sh);
        w_ang_new   = r_pred;
        if (r_mask[r_ch]) begin
            w_ang_new = r_seed[r_ch] ? sat_ang(w_corr_sum) : r_acc[r_ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch        <= '0;
            r_mask      <= '0;
            r_seed      <= '0;
            r_pred      <= '0;
            r_angle_out <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_gyro[c] <= '0;
                r_acc[c]  <= '0;
                r_ang[c]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.zero) begin
                        r_seed      <= '0;
                        r_angle_out <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_ang[c] <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_ch   <= '0;
                    r_mask <= bus.acc_mask;
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_gyro[c] <= bus.gyro_in[c*DATA_W +: DATA_W];
                        r_acc[c]  <= bus.acc_ang_in[c*ANG_W +: ANG_W];
                    end
                end
                S_PREDICT: begin
                    r_pred <= w_pred;
                end
                S_CORRECT: begin
                    r_ang[r_ch] <= w_ang_new;
                    if (r_mask[r_ch]) begin
                        r_seed[r_ch] <= 1'b1;
                    end
                    if (w_last_ch) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_angle_out[c*ANG_W +: ANG_W] <= (CH_W'(c) == r_ch) ? w_ang_new : r_ang[c];
                        end
                    end else begin
                        r_ch <= r_ch + CH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMU_FUSION_GYRO_BIAS_CAL_EN
    localparam int ACC_W = DATA_W + CAL_SHIFT;
    localparam logic [CAL_SHIFT:0] CAL_LAST = (CAL_SHIFT+1)'((1 << CAL_SHIFT) - 1);

    logic signed [ACC_W-1:0]    r_cal_acc [NUM_CH];
    logic signed [DATA_W-1:0]   r_bias    [NUM_CH];
    logic [CAL_SHIFT:0]         r_cal_cnt;
    logic                       r_cal_done;

    // Raw samples are summed at capture; the bias becomes live once the last sample is acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cal_cnt  <= '0;
            r_cal_done <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_cal_acc[c] <= '0;
                r_bias[c]    <= '0;
            end
        end else if (!r_cal_done) begin
            if (r_state == S_CAPTURE) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_cal_acc[c] <= r_cal_acc[c] + ACC_W'($signed(bus.gyro_in[c*DATA_W +: DATA_W]));
                end
            end
            if (r_state == S_ACK) begin
                r_cal_cnt <= r_cal_cnt + (CAL_SHIFT+1)'(1);
                if (r_cal_cnt == CAL_LAST) begin
                    r_cal_done <= 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_bias[c] <= DATA_W'(r_cal_acc[c] >>> CAL_SHIFT);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_bias[c] = r_bias[c];
        end
    end
    assign w_cal_active = ~r_cal_done;
    assign bus.cal_done = r_cal_done;
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_bias[c] = '0;
        end
    end
    assign w_cal_active = 1'b0;
    assign bus.cal_done = 1'b1;
`endif

    assign bus.fuse_ack  = w_ack;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.angle_out = r_angle_out;

endmodule

// File: tb/tb_imu_fusion_core.sv
// Directed bench for imu_fusion_core: NUM_CH=3, ALPHA_SHIFT=2, GYRO_SHL=0, ANG_W=32.
// Bias calibration scenario runs instead of the filter scenarios when IMU_FUSION_GYRO_BIAS_CAL_EN is defined.
module tb_imu_fusion_core;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 16;
    localparam int ANG_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    imu_fusion_core_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ANG_W(ANG_W)) bus_if ();

    imu_fusion_core #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ANG_W(ANG_W),
        .GYRO_SHL(0), .ALPHA_SHIFT(2), .CAL_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [ANG_W-1:0] ang(input int c);
        return $signed(bus_if.angle_out[c*ANG_W +: ANG_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // One full transaction; req is dropped once busy is seen, optional zero pulse while busy.
    task automatic txn(input logic signed [15:0] g0, g1, g2,
                       input logic signed [31:0] a0, a1, a2,
                       input logic [2:0] m, input bit zmid);
        bit got;
        int start;
        got   = 0;
        start = -1;
        bus_if.gyro_in    = {g2, g1, g0};
        bus_if.acc_ang_in = {a2, a1, a0};
        bus_if.acc_mask   = m;
        bus_if.fuse_req   = 1'b1;
        for (int k = 1; k <= 40 && !got; k++) begin
            tick();
            if (start < 0 && bus_if.busy) begin
                start = k;
                bus_if.fuse_req = 1'b0;
            end
            if (zmid && start >= 0 && k == start + 2) bus_if.zero = 1'b1;
            if (zmid && start >= 0 && k == start + 4) bus_if.zero = 1'b0;
            if (bus_if.fuse_ack) got = 1;
        end
        bus_if.fuse_req = 1'b0;
        bus_if.zero     = 1'b0;
        chk("txn_ack", got, 1);
    endtask

    initial begin
        int ack_cnt;
        int ack_cyc;
        bus_if.fuse_req   = 1'b0;
        bus_if.zero       = 1'b0;
        bus_if.gyro_in    = '0;
        bus_if.acc_ang_in = '0;
        bus_if.acc_mask   = '0;

        // reset state and basic latency
        do_reset();
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_ack", bus_if.fuse_ack, 0);
        chk("rst_angle_nz", |bus_if.angle_out, 0);
`ifdef IMU_FUSION_GYRO_BIAS_CAL_EN
        chk("rst_cal_done", bus_if.cal_done, 0);
`else
        chk("rst_cal_done", bus_if.cal_done, 1);
`endif
        bus_if.fuse_req = 1'b1;
        ack_cnt = 0;
        ack_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) begin
                chk("lat_busy_c1", bus_if.busy, 1);
                bus_if.fuse_req = 1'b0;
            end
            if (k == 7) chk("lat_angle_pre", |bus_if.angle_out, 0);
            if (bus_if.fuse_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = k;
            end
        end
        chk("lat_ack_cycle", ack_cyc, 8);
        chk("lat_ack_count", ack_cnt, 1);

        // reset in the middle of a transaction
        bus_if.acc_ang_in = {32'sd300, 32'sd200, 32'sd100};
        bus_if.acc_mask   = 3'b111;
        bus_if.fuse_req   = 1'b1;
        ack_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) bus_if.fuse_req = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 5) rst = 1'b0;
            if (bus_if.fuse_ack) ack_cnt++;
        end
        chk("midrst_ack_count", ack_cnt, 0);
        chk("midrst_busy", bus_if.busy, 0);
        chk("midrst_angle_nz", |bus_if.angle_out, 0);

`ifdef IMU_FUSION_GYRO_BIAS_CAL_EN
        do_reset();
        for (int t = 0; t < 16; t++) begin
            txn(16'sd0, 16'sd0, 16'sd7, 32'sd0, 32'sd0, 32'sd0, 3'b000, 0);
            tick();
            if (t == 14) chk("cal_done_15", bus_if.cal_done, 0);
        end
        chk("cal_done_16", bus_if.cal_done, 1);
        chk("cal_ch2_hold", ang(2), 0);
        txn(16'sd0, 16'sd0, 16'sd10, 32'sd0, 32'sd0, 32'sd0, 3'b000, 0);
        chk("cal_ch2_debiased", ang(2), 3);
        chk("cal_ch0", ang(0), 0);
`else
        // seeding and gyro-only channel
        txn(16'sd0, 16'sd0, 16'sd0, 32'sd1000, 32'sd2000, 32'sd999, 3'b011, 0);
        chk("seed_ch0", ang(0), 1000);
        chk("seed_ch1", ang(1), 2000);
        chk("seed_ch2", ang(2), 0);

        // integration over ten samples
        for (int t = 0; t < 10; t++) begin
            txn(16'sd0, 16'sd0, 16'sd5, 32'sd0, 32'sd0, 32'sd0, 3'b000, 0);
        end
        chk("int_ch0", ang(0), 1000);
        chk("int_ch1", ang(1), 2000);
        chk("int_ch2", ang(2), 50);

        // correction toward accel, both signs of error
        txn(16'sd0, 16'sd0, 16'sd0, 32'sd1400, 32'sd0, 32'sd0, 3'b001, 0);
        chk("corr_up_ch0", ang(0), 1100);
        chk("corr_up_ch2", ang(2), 50);
        txn(16'sd0, 16'sd0, 16'sd0, 32'sd1000, 32'sd0, 32'sd0, 3'b001, 0);
        chk("corr_dn_ch0", ang(0), 1075);
        chk("corr_dn_ch1", ang(1), 2000);

        // positive saturation; zero while busy must be ignored
        txn(16'sd0, 16'sd0, 16'sd0, 32'sd0, 32'sd0, 32'sd2147483548, 3'b100, 0);
        chk("preset_ch2", ang(2), 64'sd2147483548);
        txn(16'sd0, 16'sd0, 16'sd32767, 32'sd0, 32'sd0, 32'sd0, 3'b000, 1);
        chk("sat_pos_ch2", ang(2), 64'sd2147483647);
        chk("zero_busy_ch0", ang(0), 1075);

        // zero together with fuse_req in IDLE
        tick();
        bus_if.gyro_in  = '0;
        bus_if.acc_mask = '0;
        bus_if.zero     = 1'b1;
        bus_if.fuse_req = 1'b1;
        tick();
        chk("zero_no_ack", bus_if.fuse_ack, 0);
        chk("zero_busy", bus_if.busy, 0);
        chk("zero_angle_nz", |bus_if.angle_out, 0);
        bus_if.zero = 1'b0;
        ack_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus_if.busy) bus_if.fuse_req = 1'b0;
            if (bus_if.fuse_ack && ack_cyc < 0) ack_cyc = k;
        end
        chk("zero_ack_cycle", ack_cyc, 8);
        chk("zero_after_ch2", ang(2), 0);

        // seeds were cleared by zero; negative saturation
        txn(16'sd0, 16'sd0, 16'sd0, -32'sd2147483638, 32'sd0, 32'sd0, 3'b001, 0);
        chk("reseed_ch0", ang(0), -64'sd2147483638);
        txn(-16'sd32768, 16'sd0, 16'sd0, 32'sd0, 32'sd0, 32'sd0, 3'b000, 0);
        chk("sat_neg_ch0", ang(0), -64'sd2147483648);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
